// File: rtl/program_loader.sv
// Program-memory writer: packs byte pairs (low byte first) into instructions
// and holds the CPU in reset until a halt word is stored or memory fills.
module program_loader #(
    parameter int              B       = 16,
    parameter int              W       = 11,
    parameter int              OPW     = 5,
    parameter logic [OPW-1:0]  HALT_OP = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_we,
    output logic [W-1:0] o_addr,
    output logic [B-1:0] o_data,
    output logic         o_cpu_reset,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_full,
    output logic [W:0]   o_count
);

    typedef enum logic [2:0] {IDLE, WAIT_LO, WAIT_HI, WRITE, DONE} state_t;

    state_t         state, state_n;
    logic [7:0]     lo, lo_n;
    logic [W-1:0]   addr_n;
    logic [B-1:0]   data_n;
    logic [W:0]     count_n;
    logic           done_n, full_n, we_n, busy_n, cpu_reset_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lo          <= '0;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_data      <= '0;
            o_count     <= '0;
            o_done      <= 1'b0;
            o_full      <= 1'b0;
            o_busy      <= 1'b0;
            o_cpu_reset <= 1'b1;
        end else begin
            state       <= state_n;
            lo          <= lo_n;
            o_we        <= we_n;
            o_addr      <= addr_n;
            o_data      <= data_n;
            o_count     <= count_n;
            o_done      <= done_n;
            o_full      <= full_n;
            o_busy      <= busy_n;
            o_cpu_reset <= cpu_reset_n;
        end
    end

    always_comb begin
        state_n = state;
        lo_n    = lo;
        addr_n  = o_addr;
        data_n  = o_data;
        count_n = o_count;
        done_n  = o_done;
        full_n  = o_full;
        we_n    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    addr_n  = '0;
                    count_n = '0;
                    done_n  = 1'b0;
                    full_n  = 1'b0;
                    state_n = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (i_rx_valid) begin
                    lo_n    = i_rx_data;
                    state_n = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // o_data is only loaded here so it stays stable outside WRITE
                if (i_rx_valid) begin
                    data_n  = {i_rx_data, lo};
                    we_n    = 1'b1;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                count_n = o_count + 1'b1;
                if (o_data[B-1 -: OPW] == HALT_OP) begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end else if (o_addr == '1) begin
                    full_n  = 1'b1;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    addr_n = o_addr + 1'b1;
                    // a byte arriving during the write is the next low byte
                    if (i_rx_valid) begin
                        lo_n    = i_rx_data;
                        state_n = WAIT_HI;
                    end else begin
                        state_n = WAIT_LO;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n      = (state_n == WAIT_LO) || (state_n == WAIT_HI) || (state_n == WRITE);
        cpu_reset_n = (state_n != DONE);
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (W=11 and W=2) share stimulus and are
// compared every cycle against a transaction-level load model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    logic        we0, cpu_reset0, busy0, done0, full0;
    logic [10:0] addr0;
    logic [15:0] data0;
    logic [11:0] count0;
    logic        we1, cpu_reset1, busy1, done1, full1;
    logic [1:0]  addr1;
    logic [15:0] data1;
    logic [2:0]  count1;

    program_loader #(.W(11)) dut0 (
        .clk(clk), .reset(reset), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_we(we0), .o_addr(addr0), .o_data(data0), .o_cpu_reset(cpu_reset0),
        .o_busy(busy0), .o_done(done0), .o_full(full0), .o_count(count0));

    program_loader #(.W(2)) dut1 (
        .clk(clk), .reset(reset), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_we(we1), .o_addr(addr1), .o_data(data1), .o_cpu_reset(cpu_reset1),
        .o_busy(busy1), .o_done(done1), .o_full(full1), .o_count(count1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // load-level model: a load is active or not; bytes pair up; a formed word is
    // presented for one cycle and then either ends the load or advances the address
    typedef struct {
        bit         active;
        bit         have_lo;
        bit         wr;
        logic [7:0] lo;
        logic [15:0] word;
        int         addr;
        int         count;
        bit         done;
        bit         full;
    } mdl_t;

    localparam mdl_t MRST = '{active: 0, have_lo: 0, wr: 0, lo: 8'h0, word: 16'h0,
                              addr: 0, count: 0, done: 0, full: 0};

    function automatic mdl_t step(input mdl_t m, input bit st, input bit v,
                                  input logic [7:0] b, input int maxa);
        mdl_t n = m;
        n.wr = 0;
        if (m.wr) begin
            n.count = m.count + 1;
            if (m.word[15:11] == 5'd0) begin
                n.active = 0; n.done = 1;
            end else if (m.addr == maxa) begin
                n.active = 0; n.done = 1; n.full = 1;
            end else begin
                n.addr = m.addr + 1;
                if (v) begin n.have_lo = 1; n.lo = b; end
            end
        end else if (!m.active) begin
            if (st) begin
                n.active = 1; n.have_lo = 0; n.addr = 0; n.count = 0; n.done = 0; n.full = 0;
            end
        end else if (v) begin
            if (!m.have_lo) begin
                n.have_lo = 1; n.lo = b;
            end else begin
                n.have_lo = 0; n.word = {b, m.lo}; n.wr = 1;
            end
        end
        return n;
    endfunction

    mdl_t m0 = MRST;
    mdl_t m1 = MRST;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0 = MRST;
            m1 = MRST;
        end else begin
            m0 = step(m0, start, rx_valid, rx_data, 2047);
            m1 = step(m1, start, rx_valid, rx_data, 3);
        end
    end

    always @(posedge clk) cnt++;

    always @(negedge clk) begin
        chk("we0",    32'(we0),        32'(m0.wr));
        chk("addr0",  32'(addr0),      32'(m0.addr));
        chk("data0",  32'(data0),      32'(m0.word));
        chk("count0", 32'(count0),     32'(m0.count));
        chk("done0",  32'(done0),      32'(m0.done));
        chk("full0",  32'(full0),      32'(m0.full));
        chk("busy0",  32'(busy0),      32'(m0.active));
        chk("cpurst0",32'(cpu_reset0), 32'(!m0.done));
        chk("we1",    32'(we1),        32'(m1.wr));
        chk("addr1",  32'(addr1),      32'(m1.addr));
        chk("data1",  32'(data1),      32'(m1.word));
        chk("count1", 32'(count1),     32'(m1.count));
        chk("done1",  32'(done1),      32'(m1.done));
        chk("full1",  32'(full1),      32'(m1.full));
        chk("busy1",  32'(busy1),      32'(m1.active));
        chk("cpurst1",32'(cpu_reset1), 32'(!m1.done));
    end

    typedef struct { int addr; logic [15:0] data; int cyc; } wr_t;
    wr_t q0[$];
    wr_t q1[$];

    always @(negedge clk) begin
        if (reset && we0) q0.push_back('{int'(addr0), data0, cnt});
        if (reset && we1) q1.push_back('{int'(addr1), data1, cnt});
    end

    task automatic tick(input bit st, input bit v, input logic [7:0] b);
        start = st; rx_valid = v; rx_data = b;
        @(posedge clk); #1;
        start = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(0, 0, 8'h00);
        reset = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic chk_wr(input string name, input wr_t w, input int a, input logic [15:0] d);
        chk({name, "_addr"}, 32'(w.addr), 32'(a));
        chk({name, "_data"}, 32'(w.data), 32'(d));
    endtask

    logic [7:0] basic[6] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00};
    logic [7:0] fullb[10] = '{8'h01, 8'h08, 8'h02, 8'h08, 8'h03, 8'h08, 8'h04, 8'h08, 8'h11, 8'h22};

    initial begin
        int t0;
        // reset state
        idle(2);
        chk("rst_cpu_reset", 32'(cpu_reset0), 32'd1);
        chk("rst_we",        32'(we0),        32'd0);
        chk("rst_done",      32'(done0),      32'd0);
        chk("rst_count",     32'(count0),     32'd0);
        chk("rst_busy",      32'(busy0),      32'd0);
        reset = 1'b1;
        idle(1);

        // basic widely spaced load
        tick(1, 0, 8'h00);
        idle(2);
        foreach (basic[i]) begin tick(0, 1, basic[i]); idle(3); end
        idle(2);
        chk("basic_nwr", 32'(q0.size()), 32'd3);
        if (q0.size() == 3) begin
            chk_wr("basic0", q0[0], 0, 16'h1234);
            chk_wr("basic1", q0[1], 1, 16'h5678);
            chk_wr("basic2", q0[2], 2, 16'h0000);
        end
        chk("basic_done",  32'(done0),      32'd1);
        chk("basic_count", 32'(count0),     32'd3);
        chk("basic_cpu",   32'(cpu_reset0), 32'd0);
        chk("basic_model_count", 32'(m0.count), 32'd3);

        // back-to-back bytes, including during WRITE
        do_reset();
        tick(1, 0, 8'h00);
        idle(1);
        tick(0, 1, basic[0]);
        t0 = cnt;
        for (int i = 1; i < 6; i++) tick(0, 1, basic[i]);
        idle(4);
        chk("b2b_nwr", 32'(q0.size()), 32'd3);
        if (q0.size() == 3) begin
            chk_wr("b2b0", q0[0], 0, 16'h1234);
            chk_wr("b2b1", q0[1], 1, 16'h5678);
            chk_wr("b2b2", q0[2], 2, 16'h0000);
            chk("b2b_cyc0", 32'(q0[0].cyc - t0), 32'd1);
            chk("b2b_cyc1", 32'(q0[1].cyc - t0), 32'd3);
            chk("b2b_cyc2", 32'(q0[2].cyc - t0), 32'd5);
        end

        // fill a 4-word memory without halt, then extra bytes
        do_reset();
        tick(1, 0, 8'h00);
        foreach (fullb[i]) begin tick(0, 1, fullb[i]); idle(1); end
        idle(3);
        chk("full_nwr", 32'(q1.size()), 32'd4);
        if (q1.size() == 4)
            for (int i = 0; i < 4; i++) chk_wr("full", q1[i], i, 16'h0801 + 16'(i));
        chk("full_full",  32'(full1),  32'd1);
        chk("full_done",  32'(done1),  32'd1);
        chk("full_count", 32'(count1), 32'd4);
        chk("full_model", 32'(m1.full), 32'd1);

        // reset in the middle of a load
        do_reset();
        tick(1, 0, 8'h00);
        tick(0, 1, 8'h34);
        idle(1);
        reset = 1'b0;
        #2;
        chk("midrst_cpu",  32'(cpu_reset0), 32'd1);
        chk("midrst_busy", 32'(busy0),      32'd0);
        idle(1);
        reset = 1'b1;
        q0.delete(); q1.delete();
        tick(1, 0, 8'h00);
        tick(0, 1, 8'hCD); idle(1);
        tick(0, 1, 8'hAB); idle(1);
        tick(0, 1, 8'h00); idle(1);
        tick(0, 1, 8'h00); idle(3);
        chk("midrst_nwr", 32'(q0.size()), 32'd2);
        if (q0.size() == 2) begin
            chk_wr("midrst0", q0[0], 0, 16'hABCD);
            chk_wr("midrst1", q0[1], 1, 16'h0000);
        end

        // ignored start in WAIT_HI, restart from DONE
        do_reset();
        tick(1, 0, 8'h00);
        tick(0, 1, 8'h01);
        tick(1, 0, 8'h00);
        tick(0, 1, 8'h00);
        idle(3);
        chk("ign_nwr", 32'(q0.size()), 32'd1);
        if (q0.size() == 1) chk_wr("ign0", q0[0], 0, 16'h0001);
        chk("ign_done", 32'(done0), 32'd1);
        tick(1, 0, 8'h00);
        chk("restart_done", 32'(done0),      32'd0);
        chk("restart_cpu",  32'(cpu_reset0), 32'd1);
        q0.delete(); q1.delete();
        tick(0, 1, 8'h55);
        tick(0, 1, 8'h00);
        idle(3);
        chk("restart_nwr", 32'(q0.size()), 32'd1);
        if (q0.size() == 1) chk_wr("restart0", q0[0], 0, 16'h0055);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
                tick($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, b);
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
